// File: rtl/systolic_mac_tile.sv
// Systolic MAC tile: nibble-serial column/row word streams feed a TILE x TILE accumulator array.
// Words and control are re-serialised one block later so tiles chain edge-to-edge.
module systolic_mac_tile #(
    parameter int unsigned NIB   = 4,
    parameter int unsigned BEATS = 4,
    parameter int unsigned TILE  = 2,
    localparam int unsigned BW   = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic [NIB-1:0] col_in,
    input  logic           col_ctrl_in,
    input  logic [NIB-1:0] row_in,
    input  logic           row_ctrl_in,
    output logic [NIB-1:0] col_out,
    output logic           col_ctrl_out,
    output logic [NIB-1:0] row_out,
    output logic           row_ctrl_out,
    output logic [BW-1:0]  beat
);
    localparam int unsigned WORD = NIB * BEATS;
    localparam int unsigned EW   = WORD / TILE;
    localparam int unsigned IW   = BEATS - 2;
    localparam int unsigned NACC = TILE * TILE;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    logic [BW-1:0]            beat_q;
    logic [(BEATS-1)*NIB-1:0] col_buf_q, row_buf_q;
    logic [BEATS-2:0]         col_cbuf_q, row_cbuf_q;
    logic [WORD-1:0]          col_obuf_q, row_obuf_q;
    logic [BEATS-1:0]         col_cobuf_q, row_cobuf_q;
    logic [NIB-1:0]           col_out_q, row_out_q;
    logic                     col_ctrl_out_q, row_ctrl_out_q;
    logic [WORD-1:0]          acc_q [NACC];
    logic [WORD-1:0]          acc_d [NACC];

    logic            boundary;
    logic [WORD-1:0] col_word, row_word, col_rd, row_rd, col_oword, row_oword;
    logic [BEATS-1:0] col_cw, row_cw;
    logic [1:0]      col_op, row_op;
    logic [IW-1:0]   col_idx, row_idx;

    assign boundary = (beat_q == LAST);
    // The current nibble completes the word on the boundary beat.
    assign col_word = {col_buf_q, col_in};
    assign row_word = {row_buf_q, row_in};
    assign col_cw   = {col_cbuf_q, col_ctrl_in};
    assign row_cw   = {row_cbuf_q, row_ctrl_in};
    assign col_op   = col_cw[BEATS-1 -: 2];
    assign row_op   = row_cw[BEATS-1 -: 2];
    assign col_idx  = col_cw[IW-1:0];
    assign row_idx  = row_cw[IW-1:0];

    always_comb begin : read_mux
        col_rd = '0;
        row_rd = '0;
        for (int k = 0; k < NACC; k++) begin
            if (col_idx == IW'(k)) col_rd = acc_q[k];
            if (row_idx == IW'(k)) row_rd = acc_q[k];
        end
    end

    assign col_oword = (col_op == 2'b10) ? col_rd : col_word;
    assign row_oword = (row_op == 2'b10) ? row_rd : row_word;

    always_comb begin : acc_next
        logic [EW-1:0] a, b;
        a     = '0;
        b     = '0;
        acc_d = acc_q;
        for (int i = 0; i < TILE; i++) begin
            for (int j = 0; j < TILE; j++) begin
                a = col_word[WORD-1-j*EW -: EW];
                b = row_word[WORD-1-i*EW -: EW];
                if (row_op == 2'b01) begin
                    acc_d[i*TILE+j] = '0;
                end else if (col_op == 2'b01) begin
                    acc_d[i*TILE+j] = acc_q[i*TILE+j] + WORD'(a) * WORD'(b);
                end else if (col_op == 2'b11) begin
                    acc_d[i*TILE+j] = acc_q[i*TILE+j] ^ WORD'({a, b});
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_q         <= '0;
            col_buf_q      <= '0;
            row_buf_q      <= '0;
            col_cbuf_q     <= '0;
            row_cbuf_q     <= '0;
            col_obuf_q     <= '0;
            row_obuf_q     <= '0;
            col_cobuf_q    <= '0;
            row_cobuf_q    <= '0;
            col_out_q      <= '0;
            row_out_q      <= '0;
            col_ctrl_out_q <= 1'b0;
            row_ctrl_out_q <= 1'b0;
            for (int k = 0; k < NACC; k++) acc_q[k] <= '0;
        end else if (ena) begin
            beat_q <= boundary ? '0 : beat_q + BW'(1);
            if (boundary) begin
                acc_q          <= acc_d;
                col_out_q      <= col_oword[WORD-1 -: NIB];
                row_out_q      <= row_oword[WORD-1 -: NIB];
                col_obuf_q     <= col_oword << NIB;
                row_obuf_q     <= row_oword << NIB;
                col_ctrl_out_q <= col_cw[BEATS-1];
                row_ctrl_out_q <= row_cw[BEATS-1];
                col_cobuf_q    <= col_cw << 1;
                row_cobuf_q    <= row_cw << 1;
            end else begin
                col_buf_q      <= {col_buf_q[(BEATS-2)*NIB-1:0], col_in};
                row_buf_q      <= {row_buf_q[(BEATS-2)*NIB-1:0], row_in};
                col_cbuf_q     <= {col_cbuf_q[BEATS-3:0], col_ctrl_in};
                row_cbuf_q     <= {row_cbuf_q[BEATS-3:0], row_ctrl_in};
                col_out_q      <= col_obuf_q[WORD-1 -: NIB];
                row_out_q      <= row_obuf_q[WORD-1 -: NIB];
                col_obuf_q     <= col_obuf_q << NIB;
                row_obuf_q     <= row_obuf_q << NIB;
                col_ctrl_out_q <= col_cobuf_q[BEATS-1];
                row_ctrl_out_q <= row_cobuf_q[BEATS-1];
                col_cobuf_q    <= col_cobuf_q << 1;
                row_cobuf_q    <= row_cobuf_q << 1;
            end
        end
    end

    assign beat         = beat_q;
    assign col_out      = col_out_q;
    assign row_out      = row_out_q;
    assign col_ctrl_out = col_ctrl_out_q;
    assign row_ctrl_out = row_ctrl_out_q;

endmodule

// File: doc/systolic_mac_tile.md
Name: systolic_mac_tile

Overview:
- Parametrised systolic tile: a TILE×TILE array of accumulators fed by nibble-serial column and row word streams, each with a 1-bit serial control stream.
- Each block of BEATS cycles assembles one column word and one row word.
- At block end the tile accumulates (integer MAC or XOR mode), clears, or reads out accumulators under control-word command.
- Data and control are forwarded to neighbouring tiles one block later, so tiles chain edge-to-edge.

Parameters:
- NIB, 4: bits per beat per data channel.
- BEATS, 4: beats per block; WORD = NIB*BEATS (16). Constraint: BEATS ≥ 3.
- TILE, 2: tile dimension; elements per word; EW = WORD/TILE (8). Constraints: WORD divisible by TILE; BEATS-2 ≥ clog2(TILE*TILE).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ena  in  1  advance enable; low = full stall
- col_in  in  NIB  column data nibble, MSB-first across the block
- col_ctrl_in  in  1  column control bit, MSB-first
- row_in  in  NIB  row data nibble
- row_ctrl_in  in  1  row control bit
- col_out  out  NIB  forwarded/read column nibble
- col_ctrl_out  out  1  forwarded column control bit
- row_out  out  NIB  forwarded/read row nibble
- row_ctrl_out  out  1  forwarded row control bit
- beat  out  clog2(BEATS)  current beat index

Behaviour:
- Reset: beat=0; all outputs 0; accumulators C[0..TILE*TILE-1] (WORD bits each) = 0; input and output buffers = 0.
- Reset mid-block discards the partial word. The first cycle after release is beat 0.
- Beat counter: increments on each posedge with ena=1 and wraps BEATS-1→0.
- ena=0 holds every register (counter, buffers, C, outputs).
- Input assembly:
  - Beats 0..BEATS-2 latch col_in/row_in/ctrl bits into input buffers.
  - At beat BEATS-1 (boundary), full word = {buffers, current nibble}, earliest beat in MSBs; same rule for the BEATS-bit control words.
- Control word decode: op = ctrl[BEATS-1:BEATS-2]; idx = ctrl[BEATS-3:0].
- Elements: element k of a word = bits [WORD-1-k*EW -: EW], unsigned. a_j comes from the column word, b_i from the row word. C index = i*TILE+j.
- Column op, applied at the boundary posedge:
  - 00 PASS: no accumulate; forward the column word.
  - 01 MAC: C[i*TILE+j] += a_j*b_i, modulo 2^WORD; forward.
  - 10 READ: the column output word is C[idx], pre-update value; no accumulate.
  - 11 XOR: C[i*TILE+j] ^= {a_j,b_i}, zero-extended/truncated to WORD; forward.
- Row op:
  - 00 PASS: forward.
  - 01 CLEAR: all C <= 0. This overrides any column MAC/XOR in the same block.
  - 10 READ: the row output word is C[idx], pre-update value.
  - 11: treated as PASS.
- READ with idx ≥ TILE*TILE returns 0.
- A READ on either channel sees the value before that same boundary's update or clear.
- Control words are forwarded unchanged on col_ctrl_out/row_ctrl_out, including READ words.
- Output:
  - Output words and control words load at the boundary posedge.
  - During beat k of the next block, col_out = output word nibble k, MSB-first; likewise for row_out and the ctrl bits.
  - Outputs are registered on posedge only.
  - Latency: a nibble entering at beat k of block n appears at beat k of block n+1, i.e. BEATS cycles later.
- Outputs change only on posedge with ena=1. They are never combinational from inputs.

Test Plan:
1. Pass (defaults): col word 0xA5C3 ctrl 0000, row word 0x1234 ctrl 0000 → next block col_out A,5,C,3; row_out 1,2,3,4; ctrl outs 0,0,0,0.
2. MAC then read: col 0x0302 ctrl 0100, row 0x0504 ctrl 0000 → C = {0x000F, 0x000A, 0x000C, 0x0008}. Following block col ctrl 1001, row ctrl 1011 → next block col_out word 0x000A, row_out word 0x0008, col_ctrl_out 1,0,0,1.
3. Wrap: after reset, two MAC blocks of col 0xFFFF, row 0xFFFF → every C = 0xFC02; READ idx0 returns 0xFC02.
4. XOR: after reset, col 0x1234 ctrl 1100, row 0x5678 ctrl 0000 → C0=0x1256, C1=0x3456, C2=0x1278, C3=0x3478.
5. Clear priority: C0=0x000F, then col MAC 0x0101 with row ctrl 0100 while col ctrl 1000 is impossible; instead use row READ+CLEAR across two blocks. Block A: row ctrl 1000 plus col MAC → row_out 0x000F (pre-update). Block B: row ctrl 0100 with col ctrl 0100 → all C = 0. Block C: READ idx0 returns 0x0000.
6. Stall/reset: ena=0 for 3 cycles mid-block → beat and outputs frozen, assembled word unchanged. rst_n=0 at beat 2 → next block starts at beat 0, outputs 0, C all 0.
